register_file_sb: RTL and testbench
===================================

REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 SHALL provide parameter DATA_W, default 64, register width in bits (>= 32).
REQ-002 SHALL provide parameter ADDR_W, default 5, register index width; the file holds 2**ADDR_W entries.
REQ-003 SHALL provide parameter ZERO_REG, default 31, index that always reads zero and ignores writes and claims.
REQ-004 SHALL provide parameter BYPASS, default 1, which enables write-to-read forwarding when set to 1.
REQ-005 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port i_rn, input, ADDR_W, read index for port 0.
REQ-008 SHALL have port i_rm, input, ADDR_W, read index for port 1.
REQ-009 SHALL have port o_reg0, output, DATA_W, read data for i_rn.
REQ-010 SHALL have port o_reg1, output, DATA_W, read data for i_rm.
REQ-011 SHALL have port i_rd, input, ADDR_W, write index.
REQ-012 SHALL have port i_dataWr, input, DATA_W, write data.
REQ-013 SHALL have port i_regWr, input, 1, write enable.
REQ-014 SHALL have port i_wMode, input, 1, write width select: 1 = 32-bit W write, 0 = full X write.
REQ-015 SHALL have port i_claim, input, 1, marks register i_claimRd as pending (an in-flight producer).
REQ-016 SHALL have port i_claimRd, input, ADDR_W, index to claim.
REQ-017 SHALL have port o_busy0, output, 1, pending status of i_rn.
REQ-018 SHALL have port o_busy1, output, 1, pending status of i_rm.
REQ-019 SHALL have port o_pendCnt, output, ADDR_W+1, number of pending registers.

Function
REQ-020 SHALL compute the effective write value as {zeros, i_dataWr[31:0]} when i_wMode=1, and as i_dataWr when i_wMode=0.
REQ-021 SHALL write the effective value into entry i_rd at the rising edge when i_regWr=1 and i_rd!=ZERO_REG.
REQ-022 SHALL make reads combinational: o_reg0 and o_reg1 equal the stored entry, with no cycle latency.
REQ-023 SHALL return 0 on any read of ZERO_REG, regardless of writes or bypass.
REQ-024 SHALL, with BYPASS=1, drive the effective write value on any read port whose index equals i_rd while i_regWr=1 and i_rd!=ZERO_REG in the same cycle.
REQ-025 SHALL, with BYPASS=0, return the old stored value in the write cycle and the new value from the next cycle.
REQ-026 SHALL keep one pending bit per entry; i_claim=1 sets bit i_claimRd at the edge, except when i_claimRd=ZERO_REG.
REQ-027 SHALL clear the pending bit of i_rd at the edge when a write to it occurs (i_regWr=1).
REQ-028 SHALL, on a simultaneous claim and write to the same index, let the claim win, so the bit stays or becomes 1 (new producer).
REQ-029 SHALL treat a claim of an already pending register as a no-op for o_pendCnt.
REQ-030 SHALL treat a write to a non-pending register as a no-op for o_pendCnt.
REQ-031 SHALL drive o_busy0 = pend[i_rn] AND NOT (BYPASS AND i_regWr AND i_rd==i_rn), and o_busy1 likewise for i_rm.
REQ-032 SHALL hold o_busy0 and o_busy1 at 0 for ZERO_REG.
REQ-033 SHALL register o_pendCnt so that it equals the population count of the pending bits after each edge.
REQ-034 SHALL make o_pendCnt change by -1, 0 or +1 per cycle, covering claim and clear of distinct indices in the same cycle.

Reset
REQ-035 SHALL, on i_rst=1, immediately clear all entries to 0, all pending bits to 0 and o_pendCnt to 0, independent of the clock.
REQ-036 SHALL ignore writes and claims while i_rst=1.
REQ-037 SHALL make an assertion of i_rst mid-operation discard all outstanding claims.
REQ-038 SHALL resume normal operation at the first rising edge after i_rst deasserts.

Verification
REQ-039 The bench SHALL cover reset: assert i_rst, read all indices -> every read returns 0, o_pendCnt=0.
REQ-040 The bench SHALL cover W and X writes: X-write 0xFFFF_0000_1234_5678 to X3, then W-write 0xAAAA_BBBB_CCCC_DDDD to X3 -> X3 reads 0x0000_0000_CCCC_DDDD.
REQ-041 The bench SHALL cover bypass: with i_rn=5 and i_regWr=1, i_rd=5, data 0x42 -> o_reg0=0x42 in the same cycle (BYPASS=1); the old value in that cycle with BYPASS=0.
REQ-042 The bench SHALL cover the zero register: write 0x99 to index 31, then claim index 31 -> reads return 0, o_busy0=0, o_pendCnt unchanged.
REQ-043 The bench SHALL cover the scoreboard: claim 7, claim 9 -> o_pendCnt=2; then write 7 together with claim 7 -> o_busy for 7 stays 1, o_pendCnt=2; then write 9 -> o_pendCnt=1.
REQ-044 The bench SHALL cover reset mid-operation: with 3 claims pending, pulse i_rst between clock edges -> o_pendCnt=0 and all busy flags 0 immediately.

Source files
------------

// File: rtl/register_file_sb.sv
// register_file_sb: 2-read / 1-write register file with a per-entry pending
// scoreboard. Reads are combinational with optional write forwarding;
// pending bits track in-flight producers and a registered count follows them.
module register_file_sb #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_rn,
    input  logic [ADDR_W-1:0] i_rm,
    output logic [DATA_W-1:0] o_reg0,
    output logic [DATA_W-1:0] o_reg1,
    input  logic [ADDR_W-1:0] i_rd,
    input  logic [DATA_W-1:0] i_dataWr,
    input  logic              i_regWr,
    input  logic              i_wMode,
    input  logic              i_claim,
    input  logic [ADDR_W-1:0] i_claimRd,
    output logic              o_busy0,
    output logic              o_busy1,
    output logic [ADDR_W:0]   o_pendCnt
);

    localparam int                NREGS  = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZR     = ADDR_W'(ZERO_REG);
    localparam logic [DATA_W-1:0] W_MASK = DATA_W'(64'h0000_0000_FFFF_FFFF);
    localparam bit                BYP    = (BYPASS == 1);
    localparam int                NPORTS = 2;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  pend;
    logic [NREGS-1:0]  pend_nxt;
    logic [ADDR_W:0]   pend_cnt;

    logic [DATA_W-1:0] wval;
    logic              we;
    logic              claim_ok;
    logic              cnt_inc;
    logic              cnt_dec;

    // W writes zero-extend the low word; X writes take the full value.
    assign wval     = i_wMode ? (i_dataWr & W_MASK) : i_dataWr;
    // Writes and claims are held off while reset is asserted.
    assign we       = i_regWr && (i_rd != ZR) && !i_rst;
    assign claim_ok = i_claim && (i_claimRd != ZR) && !i_rst;

    // Count moves by at most one: a new claim adds, a clearing write subtracts
    // unless a same-index claim re-arms the bit in the same cycle.
    assign cnt_inc  = claim_ok && !pend[i_claimRd];
    assign cnt_dec  = i_regWr && !i_rst && pend[i_rd] &&
                      !(claim_ok && (i_claimRd == i_rd));

    // Register storage: async clear, single write port.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[i_rd] <= wval;
        end
    end

    // Next pending vector: write clears, claim sets afterwards so it wins.
    always_comb begin
        pend_nxt = pend;
        if (i_regWr) pend_nxt[i_rd] = 1'b0;
        if (claim_ok) pend_nxt[i_claimRd] = 1'b1;
    end

    // Pending bits and their running population count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_nxt;
            pend_cnt <= pend_cnt + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
        end
    end

    logic [NPORTS-1:0][ADDR_W-1:0] rsel;
    logic [NPORTS-1:0][DATA_W-1:0] rdat;
    logic [NPORTS-1:0]             rbusy;

    assign rsel = {i_rm, i_rn};

    // Identical read ports: zero register, then forwarding, then storage.
    for (genvar p = 0; p < NPORTS; p++) begin : g_rd
        logic hit;
        assign hit      = BYP && i_regWr && (i_rd == rsel[p]);
        assign rdat[p]  = (rsel[p] == ZR) ? '0 :
                          (hit && we)     ? wval : regs[rsel[p]];
        assign rbusy[p] = pend[rsel[p]] && !hit && (rsel[p] != ZR);
    end

    assign o_reg0    = rdat[0];
    assign o_reg1    = rdat[1];
    assign o_busy0   = rbusy[0];
    assign o_busy1   = rbusy[1];
    assign o_pendCnt = pend_cnt;

endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: drives a forwarding and a non-forwarding instance with
// the same stimulus; a driver pushes model predictions, a monitor checks them.
module tb_register_file_sb;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int ZR = 31;
    localparam int N  = 32;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [AW-1:0] i_rn, i_rm, i_rd, i_claimRd;
    logic [DW-1:0] i_dataWr;
    logic          i_regWr, i_wMode, i_claim;

    logic [DW-1:0] reg0_a, reg1_a, reg0_b, reg1_b;
    logic          busy0_a, busy1_a, busy0_b, busy1_b;
    logic [AW:0]   cnt_a, cnt_b;

    always #5 i_clk = ~i_clk;

    register_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR), .BYPASS(1)) dut_byp (
        .i_clk(i_clk), .i_rst(i_rst), .i_rn(i_rn), .i_rm(i_rm),
        .o_reg0(reg0_a), .o_reg1(reg1_a), .i_rd(i_rd), .i_dataWr(i_dataWr),
        .i_regWr(i_regWr), .i_wMode(i_wMode), .i_claim(i_claim), .i_claimRd(i_claimRd),
        .o_busy0(busy0_a), .o_busy1(busy1_a), .o_pendCnt(cnt_a)
    );

    register_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR), .BYPASS(0)) dut_nob (
        .i_clk(i_clk), .i_rst(i_rst), .i_rn(i_rn), .i_rm(i_rm),
        .o_reg0(reg0_b), .o_reg1(reg1_b), .i_rd(i_rd), .i_dataWr(i_dataWr),
        .i_regWr(i_regWr), .i_wMode(i_wMode), .i_claim(i_claim), .i_claimRd(i_claimRd),
        .o_busy0(busy0_b), .o_busy1(busy1_b), .o_pendCnt(cnt_b)
    );

    typedef struct {
        logic [DW-1:0] r0a, r1a, r0b, r1b;
        logic          b0a, b1a, b0b, b1b;
        logic [AW:0]   cnt;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mem [N];
    logic [N-1:0]  pend;
    int            n_checks = 0;
    int            n_err    = 0;

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endfunction

    function automatic logic [DW-1:0] eff_val();
        return i_wMode ? {32'h0, i_dataWr[31:0]} : i_dataWr;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) mem[i] = '0;
        pend = '0;
    endfunction

    // Architectural effect of one rising edge with the inputs currently applied.
    function automatic void model_edge();
        if (i_rst) begin
            model_clear();
        end else begin
            if (i_regWr && i_rd != ZR) mem[i_rd] = eff_val();
            if (i_regWr) pend[i_rd] = 1'b0;
            if (i_claim && i_claimRd != ZR) pend[i_claimRd] = 1'b1;
        end
    endfunction

    function automatic exp_t predict();
        exp_t e;
        logic wr_now;
        wr_now = i_regWr && (i_rd != ZR) && !i_rst;
        e.r0b  = (i_rn == ZR) ? '0 : mem[i_rn];
        e.r1b  = (i_rm == ZR) ? '0 : mem[i_rm];
        e.r0a  = (i_rn != ZR && wr_now && i_rd == i_rn) ? eff_val() : e.r0b;
        e.r1a  = (i_rm != ZR && wr_now && i_rd == i_rm) ? eff_val() : e.r1b;
        e.b0b  = pend[i_rn];
        e.b1b  = pend[i_rm];
        e.b0a  = pend[i_rn] && !(i_regWr && i_rd == i_rn);
        e.b1a  = pend[i_rm] && !(i_regWr && i_rd == i_rm);
        e.cnt  = (AW+1)'($countones(pend));
        return e;
    endfunction

    // One cycle of stimulus; a pulsed reset rises and falls between edges.
    task automatic cycle(input logic rst, input logic pulse,
                         input logic [AW-1:0] rn, input logic [AW-1:0] rm,
                         input logic [AW-1:0] rd, input logic [DW-1:0] data,
                         input logic wr, input logic wm, input logic cl,
                         input logic [AW-1:0] crd);
        @(posedge i_clk);
        model_edge();
        #1;
        i_rst = rst; i_rn = rn; i_rm = rm; i_rd = rd; i_dataWr = data;
        i_regWr = wr; i_wMode = wm; i_claim = cl; i_claimRd = crd;
        if (rst) model_clear();
        exp_q.push_back(predict());
        if (pulse) begin
            #6;
            i_rst = 1'b0;
        end
    endtask

    // Monitor: outputs are stable mid-cycle; compare against the oldest prediction.
    always @(negedge i_clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("reg0_byp",  reg0_a, e.r0a);
            chk("reg1_byp",  reg1_a, e.r1a);
            chk("reg0_nob",  reg0_b, e.r0b);
            chk("reg1_nob",  reg1_b, e.r1b);
            chk("busy0_byp", DW'(busy0_a), DW'(e.b0a));
            chk("busy1_byp", DW'(busy1_a), DW'(e.b1a));
            chk("busy0_nob", DW'(busy0_b), DW'(e.b0b));
            chk("busy1_nob", DW'(busy1_b), DW'(e.b1b));
            chk("cnt_byp",   DW'(cnt_a),   DW'(e.cnt));
            chk("cnt_nob",   DW'(cnt_b),   DW'(e.cnt));
        end
    end

    initial begin
        logic [AW-1:0] rn, rm, rd, crd;
        logic          pulse;
        i_rst = 1'b1; i_rn = '0; i_rm = '0; i_rd = '0; i_dataWr = '0;
        i_regWr = 1'b0; i_wMode = 1'b0; i_claim = 1'b0; i_claimRd = '0;
        model_clear();

        // Held reset: every index reads zero; writes and claims are ignored.
        for (int i = 0; i < N; i++)
            cycle(1'b1, 1'b0, AW'(i), AW'(N-1-i), AW'(i), 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b0, 1'b1, AW'(i));

        // X write then W write to register 3, then read back.
        cycle(1'b0, 1'b0, 5'd3, 5'd3, 5'd3, 64'hFFFF_0000_1234_5678, 1'b1, 1'b0, 1'b0, 5'd0);
        cycle(1'b0, 1'b0, 5'd3, 5'd3, 5'd3, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 1'b1, 1'b0, 5'd0);
        cycle(1'b0, 1'b0, 5'd3, 5'd0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0);

        // Forwarding on register 5: old value 0x11, new value 0x42.
        cycle(1'b0, 1'b0, 5'd6, 5'd6, 5'd5, 64'h11, 1'b1, 1'b0, 1'b0, 5'd0);
        cycle(1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 64'h42, 1'b1, 1'b0, 1'b0, 5'd0);
        cycle(1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0);

        // Zero register ignores writes and claims.
        cycle(1'b0, 1'b0, 5'd31, 5'd31, 5'd31, 64'h99, 1'b1, 1'b0, 1'b0, 5'd0);
        cycle(1'b0, 1'b0, 5'd31, 5'd31, 5'd0, 64'h0, 1'b0, 1'b0, 1'b1, 5'd31);
        cycle(1'b0, 1'b0, 5'd31, 5'd31, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0);

        // Scoreboard: claim 7, claim 9, write+reclaim 7, write 9.
        cycle(1'b0, 1'b0, 5'd7, 5'd9, 5'd0, 64'h0, 1'b0, 1'b0, 1'b1, 5'd7);
        cycle(1'b0, 1'b0, 5'd7, 5'd9, 5'd0, 64'h0, 1'b0, 1'b0, 1'b1, 5'd9);
        cycle(1'b0, 1'b0, 5'd7, 5'd9, 5'd7, 64'h77, 1'b1, 1'b0, 1'b1, 5'd7);
        cycle(1'b0, 1'b0, 5'd7, 5'd9, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        cycle(1'b0, 1'b0, 5'd7, 5'd9, 5'd9, 64'h99, 1'b1, 1'b0, 1'b0, 5'd0);
        cycle(1'b0, 1'b0, 5'd7, 5'd9, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0);

        // Three more claims, then a reset pulse between edges discards them.
        cycle(1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 64'h0, 1'b0, 1'b0, 1'b1, 5'd1);
        cycle(1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 64'h0, 1'b0, 1'b0, 1'b1, 5'd2);
        cycle(1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 64'h0, 1'b0, 1'b0, 1'b1, 5'd4);
        cycle(1'b0, 1'b0, 5'd1, 5'd4, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        cycle(1'b1, 1'b1, 5'd1, 5'd2, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        cycle(1'b0, 1'b0, 5'd4, 5'd7, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0);

        // Random traffic with occasional reset pulses and read/write collisions.
        for (int k = 0; k < 400; k++) begin
            rn    = AW'($urandom_range(0, N-1));
            rm    = AW'($urandom_range(0, N-1));
            rd    = AW'($urandom_range(0, N-1));
            crd   = AW'($urandom_range(0, N-1));
            if ($urandom_range(0, 3) == 0) rn = rd;
            if ($urandom_range(0, 3) == 0) rm = rd;
            if ($urandom_range(0, 5) == 0) crd = rd;
            pulse = ($urandom_range(0, 49) == 0);
            cycle(pulse, pulse, rn, rm, rd, {$urandom(), $urandom()},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), crd);
        end

        repeat (3) @(posedge i_clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: got %0d pending predictions expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
